// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the shared 8-bit register bank port.
// Each master owns a 1-deep request slot; accesses are serialised one at a time.
//
// state | meaning
// IDLE  | no access in flight; pick an owner when a slot is valid
// ISSUE | the single reg_en-high cycle
// WAIT  | read latency countdown before sampling bank read data
// DONE  | ack pulse, owner slot released, lock/round-robin updated
module reg_bus_arbiter #(
   parameter int READ_LAT = 1,
   parameter int RR_INIT  = 1
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       m0_req,
   input  logic       m0_we,
   input  logic [7:0] m0_addr,
   input  logic [7:0] m0_wdata,
   input  logic       m0_lock,
   output logic       m0_busy,
   output logic       m0_ack,
   output logic [7:0] m0_rdata,
   input  logic       m1_req,
   input  logic       m1_we,
   input  logic [7:0] m1_addr,
   input  logic [7:0] m1_wdata,
   input  logic       m1_lock,
   output logic       m1_busy,
   output logic       m1_ack,
   output logic [7:0] m1_rdata,
   output logic [7:0] address,
   output logic [7:0] data_write_to_reg,
   input  logic [7:0] data_read_from_reg,
   output logic       reg_en,
   output logic       write_en,
   output logic [1:0] overflow,
   input  logic       ovf_clr,
   output logic [1:0] grant_mon
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       owner, owner_nxt;
   logic       lock_v, lock_v_nxt;
   logic       lock_id, lock_id_nxt;
   logic       last_grant, last_grant_nxt;
   logic       start, to_done, sample, finish;
   logic       gnt_ok, gnt_id;

   logic [1:0] req, req_we, lock_in, clr;
   logic [7:0] req_addr  [2];
   logic [7:0] req_wdata [2];
   logic [1:0] slot_v, slot_we;
   logic [7:0] slot_addr  [2];
   logic [7:0] slot_wdata [2];

   logic [1:0] ack_q, ovf_q, grant_q;
   logic [7:0] rdata_q [2];
   logic [7:0] addr_q, wdata_q;
   logic       reg_en_q, write_en_q;

   assign req          = {m1_req, m0_req};
   assign req_we       = {m1_we, m0_we};
   assign lock_in      = {m1_lock, m0_lock};
   assign req_addr[0]  = m0_addr;
   assign req_addr[1]  = m1_addr;
   assign req_wdata[0] = m0_wdata;
   assign req_wdata[1] = m1_wdata;
   assign clr          = finish ? (owner ? 2'b10 : 2'b01) : 2'b00;

   // A lock whose level has dropped no longer restricts arbitration.
   always_comb begin
      gnt_ok = 1'b0;
      gnt_id = 1'b0;
      if (lock_v && lock_in[lock_id]) begin
         gnt_ok = slot_v[lock_id];
         gnt_id = lock_id;
      end else if (&slot_v) begin
         gnt_ok = 1'b1;
         gnt_id = ~last_grant;
      end else if (|slot_v) begin
         gnt_ok = 1'b1;
         gnt_id = slot_v[1];
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      owner_nxt      = owner;
      lock_v_nxt     = lock_v;
      lock_id_nxt    = lock_id;
      last_grant_nxt = last_grant;
      start          = 1'b0;
      to_done        = 1'b0;
      sample         = 1'b0;
      finish         = 1'b0;
      case (state)
         IDLE: begin
            if (lock_v && !lock_in[lock_id]) lock_v_nxt = 1'b0;
            if (gnt_ok) begin
               owner_nxt = gnt_id;
               start     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (slot_we[owner]) begin
               to_done   = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt   = 4'(READ_LAT - 1);
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               sample    = 1'b1;
               to_done   = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         DONE: begin
            finish         = 1'b1;
            last_grant_nxt = owner;
            lock_v_nxt     = lock_in[owner];
            lock_id_nxt    = owner;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         owner      <= 1'b0;
         lock_v     <= 1'b0;
         lock_id    <= 1'b0;
         last_grant <= 1'(RR_INIT);
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         owner      <= owner_nxt;
         lock_v     <= lock_v_nxt;
         lock_id    <= lock_id_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // A slot released on this edge counts as empty for an arriving request.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         slot_v  <= 2'b00;
         slot_we <= 2'b00;
         ovf_q   <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            slot_addr[i]  <= 8'h00;
            slot_wdata[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (req[i] && (!slot_v[i] || clr[i])) begin
               slot_v[i]     <= 1'b1;
               slot_we[i]    <= req_we[i];
               slot_addr[i]  <= req_addr[i];
               slot_wdata[i] <= req_wdata[i];
            end else if (clr[i]) begin
               slot_v[i] <= 1'b0;
            end
            if (req[i] && slot_v[i] && !clr[i]) ovf_q[i] <= 1'b1;
            else if (ovf_clr)                   ovf_q[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         reg_en_q   <= 1'b0;
         write_en_q <= 1'b0;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         grant_q    <= 2'b00;
         ack_q      <= 2'b00;
         rdata_q[0] <= 8'h00;
         rdata_q[1] <= 8'h00;
      end else begin
         reg_en_q   <= start;
         write_en_q <= start & slot_we[gnt_id];
         if (start) begin
            addr_q  <= slot_addr[gnt_id];
            wdata_q <= slot_wdata[gnt_id];
            grant_q <= gnt_id ? 2'b10 : 2'b01;
         end else if (finish) begin
            grant_q <= 2'b00;
         end
         ack_q <= to_done ? (owner ? 2'b10 : 2'b01) : 2'b00;
         if (sample) rdata_q[owner] <= data_read_from_reg;
      end
   end

   assign m0_busy           = slot_v[0];
   assign m1_busy           = slot_v[1];
   assign m0_ack            = ack_q[0];
   assign m1_ack            = ack_q[1];
   assign m0_rdata          = rdata_q[0];
   assign m1_rdata          = rdata_q[1];
   assign address           = addr_q;
   assign data_write_to_reg = wdata_q;
   assign reg_en            = reg_en_q;
   assign write_en          = write_en_q;
   assign overflow          = ovf_q;
   assign grant_mon         = grant_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed and randomized bench for reg_bus_arbiter with a simple bank memory
// and a transaction-level model of slots, arbitration order and read data.
module tb_reg_bus_arbiter;

   logic       clk = 1'b0;
   logic       resetb;
   logic       m0_req, m0_we, m0_lock, m0_busy, m0_ack;
   logic [7:0] m0_addr, m0_wdata, m0_rdata;
   logic       m1_req, m1_we, m1_lock, m1_busy, m1_ack;
   logic [7:0] m1_addr, m1_wdata, m1_rdata;
   logic [7:0] address, data_write_to_reg, data_read_from_reg;
   logic       reg_en, write_en, ovf_clr;
   logic [1:0] overflow, grant_mon;

   int total = 0;
   int bad   = 0;
   int n_acc0 = 0;
   int n_acc1 = 0;

   logic [7:0] mem [256] = '{default: 8'h00};

   reg_bus_arbiter #(.READ_LAT(1), .RR_INIT(1)) dut (
      .clk(clk), .resetb(resetb),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_busy(m0_busy), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_busy(m1_busy), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .address(address), .data_write_to_reg(data_write_to_reg),
      .data_read_from_reg(data_read_from_reg), .reg_en(reg_en), .write_en(write_en),
      .overflow(overflow), .ovf_clr(ovf_clr), .grant_mon(grant_mon)
   );

   always #5 clk = ~clk;

   assign data_read_from_reg = mem[address];

   always @(posedge clk) begin
      if (reg_en === 1'b1) begin
         if (write_en === 1'b1) mem[address] <= data_write_to_reg;
         if (grant_mon == 2'b01) n_acc0 <= n_acc0 + 1;
         if (grant_mon == 2'b10) n_acc1 <= n_acc1 + 1;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetb = 1'b0;
      tick();
      tick();
      resetb = 1'b1;
      tick();
   endtask

   task automatic issue(input int m, input logic we, input logic [7:0] a, input logic [7:0] d);
      if (m == 0) begin
         m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
      end else begin
         m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
      end
      tick();
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   task automatic wait_ack(input int m, input string tag);
      int n = 0;
      while (((m == 0) ? m0_ack : m1_ack) !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 50), 32'd1);
   endtask

   // transaction-level model state for the randomized phase
   int         last_srv;
   bit         pv  [2];
   bit         pwe [2];
   logic [7:0] pa  [2];
   logic [7:0] pd  [2];
   logic [7:0] mm  [8];
   logic [7:0] mr  [2];
   logic [1:0] prev_b, ackv;
   logic [7:0] rdv [2];
   int         w, a0, a1;
   bit         saw_ack;

   initial begin
      resetb = 1'b0;
      {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock, ovf_clr} = '0;
      m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
      tick();
      tick();
      chk("rst_reg_en", reg_en, 0);
      chk("rst_write_en", write_en, 0);
      chk("rst_grant", grant_mon, 0);
      chk("rst_busy", {m1_busy, m0_busy}, 0);
      chk("rst_ack", {m1_ack, m0_ack}, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_addr", {address, data_write_to_reg}, 0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
      resetb = 1'b1;
      tick();

      // single write from m0
      issue(0, 1'b1, 8'h12, 8'hA5);
      chk("wr_busy", m0_busy, 1);
      chk("wr_early_en", reg_en, 0);
      tick();
      chk("wr_en", {reg_en, write_en}, 2'b11);
      chk("wr_addr", address, 8'h12);
      chk("wr_data", data_write_to_reg, 8'hA5);
      chk("wr_grant", grant_mon, 2'b01);
      tick();
      chk("wr_en_drop", reg_en, 0);
      chk("wr_ack", m0_ack, 1);
      chk("wr_rdata_kept", m0_rdata, 0);
      tick();
      chk("wr_ack_drop", {m0_ack, m0_busy}, 0);
      chk("wr_grant_idle", grant_mon, 0);
      chk("wr_addr_hold", address, 8'h12);
      chk("wr_bank", mem[8'h12], 8'hA5);

      // read by m1 of a location seeded with 0x3C
      issue(0, 1'b1, 8'h40, 8'h3C);
      wait_ack(0, "seed_ack");
      tick();
      issue(1, 1'b0, 8'h40, 8'h00);
      chk("rd_busy", m1_busy, 1);
      tick();
      chk("rd_en", {reg_en, write_en}, 2'b10);
      chk("rd_addr", address, 8'h40);
      chk("rd_grant", grant_mon, 2'b10);
      tick();
      chk("rd_no_early_ack", {reg_en, m1_ack}, 0);
      tick();
      chk("rd_ack", m1_ack, 1);
      chk("rd_data", m1_rdata, 8'h3C);
      tick();
      chk("rd_ack_drop", m1_ack, 0);
      chk("rd_data_hold", m1_rdata, 8'h3C);

      // simultaneous requests after reset: m0 wins the first tie
      do_reset();
      m0_we = 1; m0_addr = 8'h30; m0_wdata = 8'h01;
      m1_we = 1; m1_addr = 8'h31; m1_wdata = 8'h02;
      m0_req = 1; m1_req = 1;
      tick();
      m0_req = 0; m1_req = 0;
      tick();
      chk("tie1_first", grant_mon, 2'b01);
      tick();
      chk("tie1_ack0", m0_ack, 1);
      tick();
      chk("tie1_gap", reg_en, 0);
      tick();
      chk("tie1_second", grant_mon, 2'b10);
      chk("tie1_addr", address, 8'h31);
      tick();
      chk("tie1_ack1", m1_ack, 1);
      tick();
      // m0 served last, so m1 wins the next tie
      issue(0, 1'b1, 8'h32, 8'h03);
      wait_ack(0, "solo_ack");
      tick();
      m0_req = 1; m1_req = 1;
      tick();
      m0_req = 0; m1_req = 0;
      tick();
      chk("tie2_first", grant_mon, 2'b10);
      wait_ack(1, "tie2_ack1");
      tick();
      wait_ack(0, "tie2_ack0");
      tick();

      // lock: m0 keeps the bus for four writes while m1 waits
      a0 = n_acc0; a1 = n_acc1;
      m0_lock = 1;
      issue(0, 1'b1, 8'h20, 8'h40);
      issue(1, 1'b1, 8'h60, 8'h77);
      for (int i = 0; i < 4; i++) begin
         wait_ack(0, "lock_ack");
         tick();
         if (i < 3) issue(0, 1'b1, 8'(8'h21 + i), 8'(8'h41 + i));
      end
      tick(); tick(); tick();
      chk("lock_m0_count", n_acc0 - a0, 4);
      chk("lock_m1_none", n_acc1 - a1, 0);
      chk("lock_m1_waiting", m1_busy, 1);
      m0_lock = 0;
      wait_ack(1, "unlock_ack");
      chk("unlock_m1_count", n_acc1 - a1, 1);
      chk("unlock_bank", mem[8'h60], 8'h77);
      tick();

      // overflow on m1 while its slot is full
      issue(0, 1'b1, 8'h52, 8'h10);
      issue(1, 1'b1, 8'h50, 8'h11);
      issue(1, 1'b1, 8'h51, 8'h22);
      chk("ovf_set", overflow, 2'b10);
      m1_req = 1; ovf_clr = 1;
      tick();
      m1_req = 0; ovf_clr = 0;
      chk("ovf_drop_wins", overflow, 2'b10);
      ovf_clr = 1;
      tick();
      ovf_clr = 0;
      chk("ovf_clr", overflow, 2'b00);
      wait_ack(1, "ovf_ack");
      issue(1, 1'b1, 8'h53, 8'h33);
      chk("ack_cycle_req_ovf", overflow, 2'b00);
      chk("ack_cycle_req_busy", m1_busy, 1);
      wait_ack(1, "ack_cycle_req_done");
      chk("ack_cycle_req_addr", address, 8'h53);
      chk("ovf_bank", mem[8'h50], 8'h11);
      tick();

      // reset during the read wait state
      issue(1, 1'b0, 8'h40, 8'h00);
      tick();
      tick();
      chk("mid_grant", grant_mon, 2'b10);
      resetb = 0;
      #1;
      chk("mid_rst_out", {reg_en, m0_ack, m1_ack, grant_mon}, 0);
      tick();
      tick();
      resetb = 1;
      saw_ack = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (m0_ack === 1'b1 || m1_ack === 1'b1) saw_ack = 1;
      end
      chk("mid_no_ack", saw_ack, 0);
      issue(0, 1'b0, 8'h40, 8'h00);
      wait_ack(0, "post_rst_ack");
      chk("post_rst_data", m0_rdata, 8'h3C);
      tick();

      // randomized traffic against the transaction model
      do_reset();
      last_srv = 1;
      for (int m = 0; m < 2; m++) begin pv[m] = 0; mr[m] = 8'h00; end
      for (int k = 0; k < 8; k++) mm[k] = mem[k];
      prev_b = 2'b00;
      for (int c = 0; c < 700; c++) begin
         if (reg_en === 1'b1) begin
            w = (prev_b == 2'b11) ? 1 - last_srv : (prev_b[1] ? 1 : 0);
            chk("rnd_grant", grant_mon, (w == 1) ? 2'b10 : 2'b01);
            chk("rnd_addr", address, pa[w]);
            chk("rnd_we", write_en, pwe[w]);
            if (pwe[w]) chk("rnd_wdata", data_write_to_reg, pd[w]);
         end
         ackv = {m1_ack, m0_ack};
         rdv[0] = m0_rdata;
         rdv[1] = m1_rdata;
         for (int m = 0; m < 2; m++) begin
            if (ackv[m]) begin
               chk("rnd_ack_pending", pv[m], 1);
               if (pwe[m]) begin
                  mm[pa[m][2:0]] = pd[m];
                  chk("rnd_rdata_kept", rdv[m], mr[m]);
               end else begin
                  mr[m] = mm[pa[m][2:0]];
                  chk("rnd_rdata", rdv[m], mr[m]);
               end
               last_srv = m;
               pv[m] = 0;
            end
         end
         prev_b = {m1_busy, m0_busy};
         m0_req = 0;
         m1_req = 0;
         if (c < 640) begin
            if (!m0_busy && $urandom_range(0, 2) == 0) begin
               m0_we = 1'($urandom_range(0, 1)); m0_addr = 8'($urandom_range(0, 7));
               m0_wdata = 8'($urandom); m0_req = 1;
               pv[0] = 1; pwe[0] = m0_we; pa[0] = m0_addr; pd[0] = m0_wdata;
            end
            if (!m1_busy && $urandom_range(0, 2) == 0) begin
               m1_we = 1'($urandom_range(0, 1)); m1_addr = 8'($urandom_range(0, 7));
               m1_wdata = 8'($urandom); m1_req = 1;
               pv[1] = 1; pwe[1] = m1_we; pa[1] = m1_addr; pd[1] = m1_wdata;
            end
         end
         tick();
      end
      chk("rnd_drained", {pv[1], pv[0]}, 0);
      chk("rnd_ovf", overflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
